// File: rtl/soft_rst_pkg.sv
// Shared types and constants for the soft-reset request initiator.
// Holds the FSM state encoding, register map, cause codes and watchdog kick value.
package soft_rst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    COOL   = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_WDT_LOAD = 2'd2;
  localparam logic [1:0] ADDR_WDT_KICK = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_CORE = 2'b01;
  localparam logic [1:0] CAUSE_SYS  = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  localparam logic [7:0] KICK_VAL = 8'h5A;

  // One counter serves both hold and cool phases, so size it for the longer one.
  function automatic int cnt_width(input int hold, input int cool);
    return $clog2(((hold > cool) ? hold : cool) + 1);
  endfunction

endpackage

// File: rtl/soft_rst_wdt.sv
// Watchdog: down-counter with keyed kick, raises a sticky pending system request on expiry.
// Latency: pending is registered on the 1->0 count edge. No backpressure; pending holds until ack.
// Only instantiated when SOFT_RST_REQ_WDT_EN is defined.
module soft_rst_wdt
  import soft_rst_pkg::*;
#(
  parameter int WDT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_we,
  input  logic [WDT_W-1:0] load_val,
  input  logic             kick_we,
  input  logic [7:0]       kick_val,
  input  logic             ack,
  output logic [WDT_W-1:0] wdt_load,
  output logic             pend
);

  logic [WDT_W-1:0] wdt_cnt;
  logic             kick_ok;
  logic             expire;

  assign kick_ok = kick_we && (kick_val == KICK_VAL);
  assign expire  = !load_we && !kick_ok && (wdt_cnt == WDT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_load <= '0;
      wdt_cnt  <= '0;
      pend     <= 1'b0;
    end else begin
      if (load_we) begin
        wdt_load <= load_val;
        wdt_cnt  <= load_val;
      end else if (kick_ok || expire) begin
        wdt_cnt <= wdt_load;
      end else if (wdt_cnt != '0) begin
        wdt_cnt <= wdt_cnt - WDT_W'(1);
      end
      // A fresh expiry outranks an ack landing in the same cycle.
      pend <= expire || (pend && !ack);
    end
  end

endmodule

// File: rtl/soft_rst_req_ctrl.sv
// Soft-reset request initiator: keyed CTRL writes (and watchdog with SOFT_RST_REQ_WDT_EN) raise held 2-bit requests.
// Latency: soft_rst_req asserts 1 cycle after an accepted write, held HOLD_CYCLES, then COOL_CYCLES dead time.
// No backpressure: requests arriving while busy are dropped silently; read data is registered one cycle later.
module soft_rst_req_ctrl
  import soft_rst_pkg::*;
#(
  parameter int         HOLD_CYCLES = 4,
  parameter int         COOL_CYCLES = 8,
  parameter logic [7:0] KEY         = 8'hA5,
  parameter int         WDT_W       = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        reg_sel,
  input  logic        reg_wr,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic [1:0]  soft_rst_req,
  output logic        busy
);

  localparam int             CW        = cnt_width(HOLD_CYCLES, COOL_CYCLES);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  COOL_LAST = CW'(COOL_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    cause;
  logic          key_err;
  logic          wr_stb;
  logic          rd_stb;
  logic          ctrl_wr;
  logic          key_ok;
  logic          ctrl_req_vld;
  logic          wdt_pend;
  logic [31:0]   rd_mux;

  assign wr_stb       = reg_sel && reg_wr;
  assign rd_stb       = reg_sel && !reg_wr;
  assign ctrl_wr      = wr_stb && (reg_addr == ADDR_CTRL);
  assign key_ok       = (reg_wdata[31:24] == KEY);
  assign ctrl_req_vld = ctrl_wr && key_ok && (reg_wdata[1:0] != 2'b00);

`ifdef SOFT_RST_REQ_WDT_EN
  logic             wdt_ack;
  logic [WDT_W-1:0] wdt_load;

  assign wdt_ack = (state == IDLE) && wdt_pend;

  soft_rst_wdt #(.WDT_W(WDT_W)) u_wdt (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load_we  (wr_stb && (reg_addr == ADDR_WDT_LOAD)),
    .load_val (reg_wdata[WDT_W-1:0]),
    .kick_we  (wr_stb && (reg_addr == ADDR_WDT_KICK)),
    .kick_val (reg_wdata[7:0]),
    .ack      (wdt_ack),
    .wdt_load (wdt_load),
    .pend     (wdt_pend)
  );
`else
  assign wdt_pend = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cause        <= CAUSE_NONE;
      soft_rst_req <= 2'b00;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Watchdog wins over a CTRL request in the same cycle.
          if (wdt_pend) begin
            state        <= ASSERT;
            cnt          <= HOLD_LAST;
            cause        <= CAUSE_WDT;
            soft_rst_req <= 2'b10;
            busy         <= 1'b1;
          end else if (ctrl_req_vld) begin
            state        <= ASSERT;
            cnt          <= HOLD_LAST;
            cause        <= (reg_wdata[1:0] == 2'b01) ? CAUSE_CORE : CAUSE_SYS;
            soft_rst_req <= reg_wdata[1:0];
            busy         <= 1'b1;
          end
        end
        ASSERT: begin
          if (cnt == '0) begin
            state        <= COOL;
            cnt          <= COOL_LAST;
            soft_rst_req <= 2'b00;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        COOL: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state        <= IDLE;
          soft_rst_req <= 2'b00;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_err <= 1'b0;
    end else if (ctrl_wr && !key_ok) begin
      key_err <= 1'b1;
    end else if (wr_stb && (reg_addr == ADDR_STATUS) && reg_wdata[1]) begin
      key_err <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_STATUS:   rd_mux = {28'd0, cause, key_err, busy};
`ifdef SOFT_RST_REQ_WDT_EN
      ADDR_WDT_LOAD: rd_mux = 32'(wdt_load);
`endif
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      reg_rdata <= '0;
    end else if (rd_stb) begin
      reg_rdata <= rd_mux;
    end
  end

endmodule

// File: doc/soft_rst_req_ctrl.md
Name: soft_rst_req_ctrl

Overview:
- Initiator side of the soft-reset request interface. Converts register writes, and optionally a watchdog timeout, into held 2-bit soft reset requests.
- soft_rst_req[0] requests a core reset; soft_rst_req[1] requests a system reset.
- These requests feed the MCU reset synchroniser, which turns them into the CPU and HAD reset outputs.
- The block sits in the power-on reset domain, so the soft resets it requests never clear it.

Parameters:
- HOLD_CYCLES, 4: cycles soft_rst_req stays asserted per request; minimum 2.
- COOL_CYCLES, 8: dead cycles after a request before a new one is accepted.
- KEY, 8'hA5: required value of CTRL wdata[31:24].
- WDT_W, 16: watchdog counter width.

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  synchronous, active-high reset (power-on domain).
- reg_sel  in  1  register access strobe, one cycle.
- reg_wr  in  1  1 = write, 0 = read (qualified by reg_sel).
- reg_addr  in  2  0 = CTRL, 1 = STATUS, 2 = WDT_LOAD, 3 = WDT_KICK.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid the cycle after a read strobe.
- soft_rst_req  out  2  [0] core request, [1] system request; registered.
- busy  out  1  request sequence in progress.

Behaviour:
- Reset values: sys_rst high at a rising sys_clk edge clears everything. soft_rst_req=0, busy=0, reg_rdata=0, FSM=IDLE, cause=00, key_err=0, wdt_load=0, wdt_cnt=0.
- FSM: IDLE -> ASSERT -> COOL -> IDLE.
- IDLE: a CTRL write with wdata[31:24]==KEY and wdata[1:0]!=0 does the following.
  - Latches req=wdata[1:0].
  - Sets cause=01 if req is 01, otherwise 10. req 11 records 10 because the system request dominates the cause.
  - Enters ASSERT.
  - soft_rst_req=req from the next cycle, so latency is 1.
- ASSERT: outputs are held for exactly HOLD_CYCLES cycles, then the FSM enters COOL and soft_rst_req=0.
- COOL: lasts COOL_CYCLES cycles, then the FSM returns to IDLE.
- busy=1 in ASSERT and COOL.
- CTRL write with the wrong key: no request; key_err is set (sticky) in any state.
- CTRL write with the correct key and wdata[1:0]==0: no-op.
- CTRL write while busy: ignored silently, with no error and no queueing.
- STATUS read layout: bit0=busy, bit1=key_err, [3:2]=cause, [31:4]=0.
- STATUS write: writing 1 to bit1 clears key_err. If a wrong-key CTRL write cannot coincide, set wins; single strobe per cycle makes this moot.
- Reads of CTRL, WDT_KICK and undefined bits return 0.
- Read data is registered and held until the next read.
- sys_rst asserted mid-ASSERT: the request is dropped immediately on that edge (soft_rst_req=0, IDLE).
- Counter widths: hold/cool counters are clog2(max(HOLD_CYCLES,COOL_CYCLES)+1) bits. No wrap occurs; each counter reloads on state entry.

Optional Feature:
- Macro: SOFT_RST_REQ_WDT_EN.
- With the macro defined, WDT_LOAD write sets wdt_load=wdata[WDT_W-1:0] and reloads wdt_cnt.
- Load 0 disables the watchdog.
- When enabled, wdt_cnt decrements each cycle.
- A WDT_KICK write with wdata[7:0]==8'h5A reloads wdt_cnt; any other kick value is ignored.
- At wdt_cnt==1 -> 0 the watchdog raises a pending system request, and wdt_cnt reloads.
  - In IDLE the pending request starts ASSERT with req=10 and cause=11.
  - If busy, the request stays pending and fires on the first IDLE cycle.
  - A watchdog request beats a same-cycle CTRL request.
- WDT_LOAD read returns wdt_load.
- Without the macro: addresses 2 and 3 read 0 and ignore writes, no counter logic exists, and cause never reads 11.

Decomposition:
- Shared package soft_rst_pkg holds:
  - the FSM state enum (IDLE, ASSERT, COOL);
  - register address constants;
  - cause codes CAUSE_NONE=00, CAUSE_CORE=01, CAUSE_SYS=10, CAUSE_WDT=11;
  - the kick constant 8'h5A.
- One natural sub-module, soft_rst_wdt, contains the watchdog counter, kick logic and pending flag. It is instantiated only under SOFT_RST_REQ_WDT_EN.

Test Plan:
- Reset, then CTRL write 0xA5000001: soft_rst_req=01 from cycle+1 for exactly 4 cycles, busy=1 for 12 cycles, STATUS reads 0x5.
- CTRL write 0x12000002: soft_rst_req stays 00 and STATUS bit1=1. STATUS write 0x2 clears it, and the next read returns 0x0 (apart from cause).
- CTRL 0xA5000003 followed by CTRL 0xA5000001 two cycles later: single 4-cycle pulse of 11, second write ignored, cause=10.
- sys_rst asserted on the 2nd ASSERT cycle: soft_rst_req=00 and busy=0 after that edge; STATUS reads 0x0.
- SOFT_RST_REQ_WDT_EN, WDT_LOAD=10, no kicks: soft_rst_req=10 appears 11 cycles after the load write, cause=11. With a 0x5A kick every 8 cycles, no request ever appears.
- SOFT_RST_REQ_WDT_EN: watchdog expires during COOL of a CTRL request; the new 10 pulse starts the cycle after COOL ends.
